// File: rtl/mips_mmio_port_pkg.sv
// Shared definitions for the mips MMIO port: register offsets, STATUS/CTRL bit
// positions and a STATUS packing helper.
package mips_mmio_port_pkg;

    // Register offsets inside the 4-byte window
    typedef enum logic [1:0] {
        OFS_DATA   = 2'd0,
        OFS_STATUS = 2'd1,
        OFS_CTRL   = 2'd2,
        OFS_RESULT = 2'd3
    } mmio_ofs_e;

    // STATUS bit positions
    localparam int unsigned ST_OVF   = 7;
    localparam int unsigned ST_FULL  = 6;
    localparam int unsigned ST_EMPTY = 5;
    localparam int unsigned ST_CNT_W = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_EN = 0;

    // STATUS layout: {ovf, full, empty, 1'b0, count[3:0]}
    function automatic logic [7:0] pack_status(input logic       ovf,
                                               input logic       full,
                                               input logic       empty,
                                               input logic [3:0] cnt);
        logic [7:0] s;
        s           = '0;
        s[ST_OVF]   = ovf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        s[ST_CNT_W-1:0] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/mips_mmio_port_fifo.sv
// Synchronous FIFO for the MMIO output stream. A push on a full FIFO is
// accepted only when a pop happens on the same edge (count stays put).
module mmio_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic                       push_ok_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_q];
    assign push_ok_o = push_i & (~full_o | pop_i);
    assign pop_ok    = pop_i & ~empty_o;

    // Next-state pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok_o) wr_d = wr_q + 1'b1;
        if (pop_ok)    rd_d = rd_q + 1'b1;
        case ({push_ok_o, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset flushes the FIFO
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk_i) begin
        if (push_ok_o) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/mips_mmio_port.sv
// Memory-side MMIO responder for the mips bus: decodes a 4-byte window,
// holds CTRL/RESULT/ovf state and a registered read mux, and streams
// DATA writes out through a ready/valid FIFO.
module mips_mmio_port
    import mips_mmio_port_pkg::*;
#(
    parameter int unsigned     WIDTH      = 8,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] BASE_ADR  = 8'hFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             memwrite,
    output logic [WIDTH-1:0] rdata,
    output logic             rd_hit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    mmio_ofs_e        ofs;
    logic             wr_hit;
    logic             push, pop, push_ok;
    logic             full, empty;
    logic [CW-1:0]    count;
    logic [7:0]       status8;

    logic             en_q,     en_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] last_q,   last_d;
    logic [WIDTH-1:0] rdata_q,  rdata_d;
    logic             rd_hit_q;

    assign hit    = (adr[WIDTH-1:2] == BASE_ADR[WIDTH-1:2]);
    assign ofs    = mmio_ofs_e'(adr[1:0]);
    assign wr_hit = memwrite & hit;

    assign out_valid = ~empty & en_q;
    assign pop       = out_valid & out_ready;
    assign push      = wr_hit & (ofs == OFS_DATA);

    assign status8 = pack_status(ovf_q, full, empty, ST_CNT_W'(count));

    mmio_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_i    (push),
        .data_i    (writedata),
        .pop_i     (pop),
        .push_ok_o (push_ok),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .head_o    (out_data)
    );

    // Next-state for control registers and the read mux (reads see pre-edge state)
    always_comb begin
        en_d     = en_q;
        ovf_d    = ovf_q;
        done_d   = done_q;
        result_d = result_q;
        last_d   = last_q;
        rdata_d  = '0;

        if (push_ok)               last_d = writedata;
        if (push && !push_ok)      ovf_d  = 1'b1;
        if (wr_hit) begin
            case (ofs)
                OFS_STATUS: ovf_d = 1'b0;
                OFS_CTRL:   en_d  = writedata[CTRL_EN];
                OFS_RESULT: begin
                    result_d = writedata;
                    done_d   = 1'b1;
                end
                default: ;
            endcase
        end

        if (hit) begin
            case (ofs)
                OFS_DATA:   rdata_d = last_q;
                OFS_STATUS: rdata_d = WIDTH'(status8);
                OFS_CTRL:   rdata_d = WIDTH'(en_q);
                OFS_RESULT: rdata_d = result_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    // Register update with synchronous reset clearing all visible state
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            last_q   <= '0;
            rdata_q  <= '0;
            rd_hit_q <= 1'b0;
        end else begin
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            result_q <= result_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            rd_hit_q <= hit;
        end
    end

    assign rdata  = rdata_q;
    assign rd_hit = rd_hit_q;
    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_mips_mmio_port.sv
// Self-checking bench for mips_mmio_port: table of bus operations with
// expected read data, plus a queue scoreboard for the output stream.
module tb_mips_mmio_port;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memwrite;
    logic [7:0] rdata;
    logic       rd_hit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: expected stream contents and drain enable
    logic [7:0] sb_q[$];
    logic       m_en = 1'b0;

    always #5 clk = ~clk;

    mips_mmio_port #(
        .WIDTH      (8),
        .FIFO_DEPTH (4),
        .BASE_ADR   (8'hFC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .rdata     (rdata),
        .rd_hit    (rd_hit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .done      (done)
    );

    typedef struct packed {
        logic       r;
        logic       we;
        logic [7:0] a;
        logic [7:0] wd;
        logic       rdy;
        logic       chk;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input logic r, input logic we, input logic [7:0] a,
                               input logic [7:0] wd, input logic rdy,
                               input logic c, input logic [7:0] e);
        vec_t x;
        x.r = r; x.we = we; x.a = a; x.wd = wd; x.rdy = rdy; x.chk = c; x.exp = e;
        return x;
    endfunction

    // One bus cycle: drive inputs, check stream before the edge, update model, check reads after
    task automatic step(input vec_t x);
        logic mpop, mpush;
        reset = x.r; memwrite = x.we; adr = x.a; writedata = x.wd; out_ready = x.rdy;
        #1;
        chk("out_valid", {7'd0, out_valid}, {7'd0, (m_en && sb_q.size() > 0)});
        mpop = m_en && (sb_q.size() > 0) && x.rdy;
        if (mpop) begin
            chk("out_data", out_data, sb_q[0]);
            void'(sb_q.pop_front());
        end
        mpush = x.we && !x.r && (x.a == 8'hFC);
        if (mpush && (sb_q.size() < 4)) sb_q.push_back(x.wd);
        if (x.we && x.a == 8'hFE) m_en = x.wd[0];
        if (x.r) begin
            sb_q.delete();
            m_en = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("rd_hit", {7'd0, rd_hit}, {7'd0, (!x.r && x.a[7:2] == 6'h3F)});
        if (x.chk) chk("rdata", rdata, x.exp);
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; adr = '0; writedata = '0; out_ready = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) step(v(1, 0, 8'hFD, 8'h00, 0, 1, 8'h00));
        chk("reset_done",   {7'd0, done}, 8'h00);
        chk("reset_result", result, 8'h00);

        // Test 1..5 as a vector table
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'h20));  // STATUS empty
        vt.push_back(v(0, 1, 8'hFF, 8'h0D, 0, 0, 8'h00));  // RESULT=0D
        vt.push_back(v(0, 0, 8'hFF, 8'h00, 0, 1, 8'h0D));
        vt.push_back(v(0, 1, 8'h10, 8'hAA, 0, 0, 8'h00));  // outside window ignored
        vt.push_back(v(0, 1, 8'hFE, 8'h00, 0, 0, 8'h00));  // en=0
        vt.push_back(v(0, 1, 8'hFC, 8'h01, 0, 0, 8'h00));
        vt.push_back(v(0, 1, 8'hFC, 8'h02, 0, 0, 8'h00));
        vt.push_back(v(0, 1, 8'hFC, 8'h03, 1, 0, 8'h00));  // ready high but en=0
        vt.push_back(v(0, 1, 8'hFC, 8'h04, 0, 0, 8'h00));
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'h44));  // full, count 4
        vt.push_back(v(0, 1, 8'hFC, 8'h05, 0, 0, 8'h00));  // rejected
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'hC4));
        vt.push_back(v(0, 0, 8'hFC, 8'h00, 0, 1, 8'h04));  // last accepted byte
        vt.push_back(v(0, 1, 8'hFE, 8'h01, 1, 0, 8'h00));  // enable drain
        for (int i = 0; i < 4; i++) vt.push_back(v(0, 0, 8'h00, 8'h00, 1, 1, 8'h00));
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 1, 1, 8'hA0));  // empty, ovf held
        vt.push_back(v(0, 1, 8'hFD, 8'h00, 1, 0, 8'h00));  // clear ovf
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 1, 1, 8'h20));
        vt.push_back(v(0, 0, 8'hFE, 8'h00, 1, 1, 8'h01));  // CTRL readback
        vt.push_back(v(0, 1, 8'hFC, 8'h11, 0, 0, 8'h00));
        vt.push_back(v(0, 1, 8'hFC, 8'h22, 0, 0, 8'h00));
        vt.push_back(v(0, 1, 8'hFC, 8'h33, 0, 0, 8'h00));
        vt.push_back(v(0, 1, 8'hFC, 8'h44, 0, 0, 8'h00));
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'h44));
        vt.push_back(v(0, 1, 8'hFC, 8'h55, 1, 0, 8'h00));  // push on full with pop
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'h44));  // ovf stays 0
        for (int i = 0; i < 4; i++) vt.push_back(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h00));
        vt.push_back(v(0, 0, 8'hFD, 8'h00, 0, 1, 8'h20));
        vt.push_back(v(0, 0, 8'hFC, 8'h00, 0, 1, 8'h55));

        for (int i = 0; i < vt.size(); i++) step(vt[i]);

        chk("result_0D", result, 8'h0D);
        chk("done_set",  {7'd0, done}, 8'h01);

        // Repeat RESULT write overwrites, done stays set
        step(v(0, 1, 8'hFF, 8'h0E, 0, 0, 8'h00));
        chk("result_0E", result, 8'h0E);
        chk("done_held", {7'd0, done}, 8'h01);

        // Reset mid-stream with bytes queued and ready toggling
        step(v(0, 1, 8'hFC, 8'hA1, 0, 0, 8'h00));
        step(v(0, 1, 8'hFC, 8'hA2, 1, 0, 8'h00));
        step(v(0, 1, 8'hFC, 8'hA3, 0, 0, 8'h00));
        step(v(0, 0, 8'h00, 8'h00, 1, 0, 8'h00));
        step(v(0, 0, 8'h00, 8'h00, 0, 0, 8'h00));
        step(v(1, 0, 8'h00, 8'h00, 1, 0, 8'h00));
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_result",    result, 8'h00);
        chk("rst_done",      {7'd0, done}, 8'h00);
        step(v(0, 0, 8'hFD, 8'h00, 1, 1, 8'h20));
        step(v(0, 0, 8'hFE, 8'h00, 1, 1, 8'h00));
        chk("sb_empty", 8'(sb_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
